// File: rtl/bin16_to_bcd_seq.sv
// rtl/bin16_to_bcd_seq.sv - sequential shift-and-add-3 binary to packed BCD converter
module bin16_to_bcd_seq #(
  parameter int BIN_W      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o,
  output logic [BCD_DIGITS-1:0]   blank_o
);

  localparam int SW    = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]      LAST_ITER   = CNT_W'(BIN_W - 1);
  localparam logic [BCD_DIGITS-1:0] BLANK_RESET = {{(BCD_DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_nx;
  logic [BIN_W-1:0]        shift_q, shift_nx;
  logic [SW-1:0]           scratch_q, scratch_nx;
  logic [SW-1:0]           adjusted;
  logic [SW+BIN_W-1:0]     joined;
  logic [CNT_W-1:0]        cnt_q, cnt_nx;
  logic [SW-1:0]           bcd_q, bcd_nx;
  logic [BCD_DIGITS-1:0]   blank_q, blank_nx;
  logic                    done_q, done_nx;

  // Leading-zero flags: a digit blanks while it and every higher digit are zero;
  // the ones digit never blanks so zero still shows a single "0".
  function automatic logic [BCD_DIGITS-1:0] blank_of(input logic [SW-1:0] v);
    logic all_zero;
    logic [BCD_DIGITS-1:0] b;
    all_zero = 1'b1;
    b = '0;
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (v[4*i +: 4] == 4'd0);
      b[i] = all_zero;
    end
    b[0] = 1'b0;
    return b;
  endfunction

  // Add-3 correction on every scratch digit >= 5, then the combined one-bit left shift.
  always_comb begin
    adjusted = scratch_q;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
    joined = {adjusted, shift_q} << 1;
  end

  // Next-state and datapath updates; results publish only on the final shift.
  always_comb begin
    state_nx   = state_q;
    shift_nx   = shift_q;
    scratch_nx = scratch_q;
    cnt_nx     = cnt_q;
    bcd_nx     = bcd_q;
    blank_nx   = blank_q;
    done_nx    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_nx   = bin_i;
          scratch_nx = '0;
          cnt_nx     = '0;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_nx = joined[SW+BIN_W-1 -: SW];
        shift_nx   = joined[BIN_W-1:0];
        cnt_nx     = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          bcd_nx   = joined[SW+BIN_W-1 -: SW];
          blank_nx = blank_of(joined[SW+BIN_W-1 -: SW]);
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset that overrides start.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RESET;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nx;
      shift_q   <= shift_nx;
      scratch_q <= scratch_nx;
      cnt_q     <= cnt_nx;
      bcd_q     <= bcd_nx;
      blank_q   <= blank_nx;
      done_q    <= done_nx;
    end
  end

  assign busy_o  = (state_q == SHIFT);
  assign done_o  = done_q;
  assign bcd_o   = bcd_q;
  assign blank_o = blank_q;

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// tb/tb_bin16_to_bcd_seq.sv - directed self-checking bench for bin16_to_bcd_seq
module tb_bin16_to_bcd_seq;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] bin_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [19:0] bcd_o;
  logic [4:0]  blank_o;

  int tests = 0;
  int fails = 0;

  bin16_to_bcd_seq dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bcd_o   (bcd_o),
    .blank_o (blank_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the accepting posedge; sample i is taken after edge N+i.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (i == 0) start_i = 1'b0;
      if (done_o) begin
        lat = i;
        break;
      end
      if (busy_o) busy_cnt++;
    end
  endtask

  task automatic convert(input string tag, input logic [15:0] v,
                         input logic [19:0] exp_bcd, input logic [4:0] exp_blank);
    int lat, bc;
    @(negedge clk_i);
    bin_i = v;
    start_i = 1'b1;
    @(posedge clk_i);
    wait_done(lat, bc);
    check({tag, "_lat"}, lat, 16);
    check({tag, "_bcd"}, bcd_o, exp_bcd);
    check({tag, "_blank"}, blank_o, exp_blank);
    @(negedge clk_i);
    check({tag, "_done_clr"}, done_o, 1'b0);
  endtask

  initial begin
    int lat, bc, seen;
    logic [15:0] vals [0:4];
    logic [19:0] exps [0:3];

    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_bcd", bcd_o, 20'h00000);
    check("rst_blank", blank_o, 5'b11110);
    reset_i = 1'b0;

    // zero: also busy width and latency
    @(negedge clk_i);
    bin_i = 16'd0;
    start_i = 1'b1;
    @(posedge clk_i);
    wait_done(lat, bc);
    check("zero_lat", lat, 16);
    check("zero_busy_cycles", bc, 16);
    check("zero_busy_at_done", busy_o, 1'b0);
    check("zero_bcd", bcd_o, 20'h00000);
    check("zero_blank", blank_o, 5'b11110);

    convert("v1234", 16'd1234, 20'h01234, 5'b10000);
    convert("v65535", 16'd65535, 20'h65535, 5'b00000);
    convert("v9", 16'd9, 20'h00009, 5'b11110);
    convert("v10", 16'd10, 20'h00010, 5'b11100);
    convert("v99", 16'd99, 20'h00099, 5'b11100);
    convert("v100", 16'd100, 20'h00100, 5'b11000);

    // start pulses while busy are ignored; next start accepted at N+17
    @(negedge clk_i);
    bin_i = 16'd500;
    start_i = 1'b1;
    @(posedge clk_i);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (i == 4 || i == 15) begin
        start_i = 1'b1;
        bin_i = 16'd7;
      end
      if (i == 5) check("ign_busy_mid", busy_o, 1'b1);
      if (i == 15) check("ign_no_early_done", done_o, 1'b0);
      if (i == 16) begin
        check("ign_done", done_o, 1'b1);
        check("ign_bcd", bcd_o, 20'h00500);
        check("ign_blank", blank_o, 5'b11000);
        start_i = 1'b1;
        bin_i = 16'd7;
      end
    end
    @(posedge clk_i);
    wait_done(lat, bc);
    check("next_lat", lat, 16);
    check("next_bcd", bcd_o, 20'h00007);

    // reset in the middle of a conversion
    convert("v42", 16'd42, 20'h00042, 5'b11100);
    @(negedge clk_i);
    bin_i = 16'd777;
    start_i = 1'b1;
    @(posedge clk_i);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (i == 7) reset_i = 1'b1;
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    check("mrst_busy", busy_o, 1'b0);
    check("mrst_done", done_o, 1'b0);
    check("mrst_bcd", bcd_o, 20'h00000);
    check("mrst_blank", blank_o, 5'b11110);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (done_o) seen++;
    end
    check("mrst_no_done", seen, 0);
    convert("v777", 16'd777, 20'h00777, 5'b11000);

    // continuous start: one result every 17 cycles
    vals[0] = 16'd300; vals[1] = 16'd301; vals[2] = 16'd302;
    vals[3] = 16'd303; vals[4] = 16'd304;
    exps[0] = 20'h00300; exps[1] = 20'h00301;
    exps[2] = 20'h00302; exps[3] = 20'h00303;
    @(negedge clk_i);
    bin_i = vals[0];
    start_i = 1'b1;
    @(posedge clk_i);
    for (int c = 0; c < 4; c++) begin
      lat = -1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_i);
        if (i == 0) bin_i = 16'hFFFF;
        if (done_o) begin
          lat = i;
          break;
        end
      end
      check($sformatf("cont%0d_lat", c), lat, 16);
      check($sformatf("cont%0d_bcd", c), bcd_o, exps[c]);
      bin_i = vals[c+1];
    end
    start_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
